// File: rtl/riscv_base_divider_pkg.sv
// Shared constants for the RV32M iterative divider: instruction mask/match pairs and default width.
package riscv_base_divider_pkg;

    localparam int unsigned INST_W       = 32;
    localparam int unsigned DIV_BITS_DEF = 32;

    localparam logic [INST_W-1:0] INST_DIV       = 32'h0200_4033;
    localparam logic [INST_W-1:0] INST_DIV_MASK  = 32'hfe00_707f;
    localparam logic [INST_W-1:0] INST_DIVU      = 32'h0200_5033;
    localparam logic [INST_W-1:0] INST_DIVU_MASK = 32'hfe00_707f;
    localparam logic [INST_W-1:0] INST_REM       = 32'h0200_6033;
    localparam logic [INST_W-1:0] INST_REM_MASK  = 32'hfe00_707f;
    localparam logic [INST_W-1:0] INST_REMU      = 32'h0200_7033;
    localparam logic [INST_W-1:0] INST_REMU_MASK = 32'hfe00_707f;

endpackage

// File: rtl/riscv_base_divider_if.sv
// Execute-stage opcode/operand inputs and writeback outputs of the divider.
interface riscv_base_divider_if
    import riscv_base_divider_pkg::*;
#(
    parameter int unsigned DIV_BITS = DIV_BITS_DEF
);
    logic                opcode_valid_i;
    logic [INST_W-1:0]   opcode_opcode_i;
    logic [DIV_BITS-1:0] opcode_ra_operand_i;
    logic [DIV_BITS-1:0] opcode_rb_operand_i;
    logic                flush_i;
    logic                busy_o;
    logic                writeback_valid_o;
    logic [DIV_BITS-1:0] writeback_value_o;

    modport master (
        output opcode_valid_i, opcode_opcode_i, opcode_ra_operand_i, opcode_rb_operand_i, flush_i,
        input  busy_o, writeback_valid_o, writeback_value_o
    );

    modport slave (
        input  opcode_valid_i, opcode_opcode_i, opcode_ra_operand_i, opcode_rb_operand_i, flush_i,
        output busy_o, writeback_valid_o, writeback_value_o
    );
endinterface

// File: rtl/riscv_base_div_step.sv
// One combinational restoring-division step: shift in a dividend bit, trial-subtract the divisor.
module riscv_base_div_step #(
    parameter int unsigned DIV_BITS = 32
) (
    input  logic [DIV_BITS:0]   rem_i,
    input  logic [DIV_BITS-1:0] divisor_i,
    input  logic                bit_i,
    output logic [DIV_BITS:0]   rem_o,
    output logic                q_o
);
    logic [DIV_BITS+1:0] shifted;
    logic [DIV_BITS+1:0] diff;

    always_comb begin
        shifted = {rem_i, bit_i};
        diff    = shifted - {2'b00, divisor_i};
        q_o     = ~diff[DIV_BITS+1];
        rem_o   = q_o ? (DIV_BITS+1)'(diff) : (DIV_BITS+1)'(shifted);
    end
endmodule

// File: rtl/riscv_base_divider.sv
// Iterative RV32M DIV/DIVU/REM/REMU unit, one quotient bit per cycle.
// Optional RISCV_DIV_EARLY_OUT_EN: skip iteration when b == 0 or |a| < |b|.
module riscv_base_divider
    import riscv_base_divider_pkg::*;
#(
    parameter int unsigned DIV_BITS = DIV_BITS_DEF
) (
    input  logic                clk_i,
    input  logic                rst_i,
    riscv_base_divider_if.slave bus
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam int unsigned       CNT_W    = $clog2(DIV_BITS);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DIV_BITS - 1);

    logic [1:0]          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DIV_BITS:0]   prem_q, prem_d;
    logic [DIV_BITS-1:0] dividend_q, dividend_d;
    logic [DIV_BITS-1:0] divisor_q, divisor_d;
    logic [DIV_BITS-1:0] result_q, result_d;
    logic                rem_q, rem_d;
    logic                qneg_q, qneg_d;
    logic                rneg_q, rneg_d;

    logic                is_signed, is_rem, accept;
    logic                sign_a, sign_b;
    logic [DIV_BITS-1:0] opa, opb, abs_a, abs_b;
    logic [DIV_BITS-1:0] quotient, remainder, final_val;
    logic [DIV_BITS:0]   step_rem;
    logic                step_bit;

    // Decode and operand magnitude preparation for the accept edge
    always_comb begin
        logic inst_div, inst_divu, inst_rem, inst_remu;
        inst_div  = (bus.opcode_opcode_i & INST_DIV_MASK)  == INST_DIV;
        inst_divu = (bus.opcode_opcode_i & INST_DIVU_MASK) == INST_DIVU;
        inst_rem  = (bus.opcode_opcode_i & INST_REM_MASK)  == INST_REM;
        inst_remu = (bus.opcode_opcode_i & INST_REMU_MASK) == INST_REMU;
        is_signed = inst_div | inst_rem;
        is_rem    = inst_rem | inst_remu;
        accept    = bus.opcode_valid_i && !bus.flush_i &&
                    (inst_div || inst_divu || inst_rem || inst_remu);
        opa       = bus.opcode_ra_operand_i;
        opb       = bus.opcode_rb_operand_i;
        sign_a    = is_signed & opa[DIV_BITS-1];
        sign_b    = is_signed & opb[DIV_BITS-1];
        abs_a     = sign_a ? (~opa + DIV_BITS'(1)) : opa;
        abs_b     = sign_b ? (~opb + DIV_BITS'(1)) : opb;
    end

    riscv_base_div_step #(.DIV_BITS(DIV_BITS)) u_step (
        .rem_i     (prem_q),
        .divisor_i (divisor_q),
        .bit_i     (dividend_q[DIV_BITS-1]),
        .rem_o     (step_rem),
        .q_o       (step_bit)
    );

    // Result of the final iteration, sign-corrected
    always_comb begin
        quotient  = {dividend_q[DIV_BITS-2:0], step_bit};
        remainder = step_rem[DIV_BITS-1:0];
        final_val = rem_q ? remainder : quotient;
        if (rem_q ? rneg_q : qneg_q) begin
            final_val = ~final_val + DIV_BITS'(1);
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        prem_d     = prem_q;
        dividend_d = dividend_q;
        divisor_d  = divisor_q;
        rem_d      = rem_q;
        qneg_d     = qneg_q;
        rneg_d     = rneg_q;
        result_d   = result_q;

        if (bus.flush_i && (state_q != ST_IDLE)) begin
            state_d = ST_IDLE;
        end else if (state_q == ST_RUN) begin
            prem_d     = step_rem;
            dividend_d = {dividend_q[DIV_BITS-2:0], step_bit};
            cnt_d      = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_LAST) begin
                state_d  = ST_DONE;
                cnt_d    = '0;
                result_d = final_val;
            end
        end else if (accept) begin
            state_d    = ST_RUN;
            cnt_d      = '0;
            prem_d     = '0;
            dividend_d = abs_a;
            divisor_d  = abs_b;
            rem_d      = is_rem;
            qneg_d     = (sign_a ^ sign_b) && (opb != '0);
            rneg_d     = sign_a;
`ifdef RISCV_DIV_EARLY_OUT_EN
            if ((opb == '0) || (abs_a < abs_b)) begin
                state_d  = ST_DONE;
                result_d = is_rem ? opa : ((opb == '0) ? {DIV_BITS{1'b1}} : '0);
            end
`endif
        end else begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            prem_q     <= '0;
            dividend_q <= '0;
            divisor_q  <= '0;
            result_q   <= '0;
            rem_q      <= 1'b0;
            qneg_q     <= 1'b0;
            rneg_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            prem_q     <= prem_d;
            dividend_q <= dividend_d;
            divisor_q  <= divisor_d;
            result_q   <= result_d;
            rem_q      <= rem_d;
            qneg_q     <= qneg_d;
            rneg_q     <= rneg_d;
        end
    end

    assign bus.busy_o            = (state_q == ST_RUN);
    assign bus.writeback_valid_o = (state_q == ST_DONE);
    assign bus.writeback_value_o = result_q;
endmodule

// File: tb/tb_riscv_base_divider.sv
// Self-checking bench for riscv_base_divider against an arithmetic reference model.
module tb_riscv_base_divider;

`ifdef RISCV_DIV_EARLY_OUT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    localparam logic [2:0] F_DIV  = 3'd4;
    localparam logic [2:0] F_DIVU = 3'd5;
    localparam logic [2:0] F_REM  = 3'd6;
    localparam logic [2:0] F_REMU = 3'd7;

    logic clk;
    logic rst_i;
    int   tests_run;
    int   tests_failed;

    riscv_base_divider_if #(.DIV_BITS(32)) bus ();

    riscv_base_divider dut (
        .clk_i (clk),
        .rst_i (rst_i),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // R-type M-extension word with random register fields
    function automatic logic [31:0] mk_inst(input logic [6:0] funct7, input logic [2:0] f3);
        return {funct7, 5'($urandom), 5'($urandom), f3, 5'($urandom), 7'b0110011};
    endfunction

    // Architectural RV32M result
    function automatic logic [31:0] ref_res(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (f3)
            F_DIV:   return (b == 0) ? 32'hFFFF_FFFF : 32'(sa / sb);
            F_DIVU:  return (b == 0) ? 32'hFFFF_FFFF : a / b;
            F_REM:   return (b == 0) ? a : 32'(sa % sb);
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // Cycles from accept edge to the sampled writeback pulse
    function automatic int exp_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] ma, mb;
        ma = (!f3[0] && a[31]) ? -a : a;
        mb = (!f3[0] && b[31]) ? -b : b;
        if (EARLY && ((b == 0) || (ma < mb))) return 0;
        return 32;
    endfunction

    // Issue one op and observe it; no checking here
    task automatic exec_op(input logic [31:0] inst, input logic [31:0] a, input logic [31:0] b,
                           output int lat, output logic [31:0] val, output int busy_cyc,
                           output logic valid_after);
        bus.opcode_valid_i      = 1'b1;
        bus.opcode_opcode_i     = inst;
        bus.opcode_ra_operand_i = a;
        bus.opcode_rb_operand_i = b;
        @(posedge clk); #1;
        bus.opcode_valid_i      = 1'b0;
        bus.opcode_ra_operand_i = $urandom;
        bus.opcode_rb_operand_i = $urandom;
        lat = -1;
        val = '0;
        busy_cyc = 0;
        for (int k = 0; k < 100; k++) begin
            if (bus.busy_o) busy_cyc++;
            if (bus.writeback_valid_o) begin
                lat = k;
                val = bus.writeback_value_o;
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        valid_after = bus.writeback_valid_o;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        tests_run++;
        if (bus.busy_o !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got %b exp 0", bus.busy_o); end
        tests_run++;
        if (bus.writeback_valid_o !== 1'b0) begin tests_failed++; $display("FAIL reset_valid got %b exp 0", bus.writeback_valid_o); end
        tests_run++;
        if (bus.writeback_value_o !== 32'h0) begin tests_failed++; $display("FAIL reset_value got %h exp 0", bus.writeback_value_o); end
        rst_i = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        logic [2:0]  f3 [9] = '{F_DIVU, F_REMU, F_DIV, F_REM, F_REM, F_DIV, F_REM, F_DIV, F_REM};
        logic [31:0] av [9] = '{32'd100, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd7, 32'd5,
                                32'hFFFF_FFFB, 32'h8000_0000, 32'h8000_0000};
        logic [31:0] bv [9] = '{32'd7, 32'd7, 32'd2, 32'd2, 32'hFFFF_FFFE, 32'd0, 32'd0,
                                32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] ev [9] = '{32'd14, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF,
                                32'hFFFF_FFFB, 32'h8000_0000, 32'd0};
        int lat, busy_cyc, el;
        logic [31:0] val;
        logic va;
        for (int i = 0; i < 9; i++) begin
            exec_op(mk_inst(7'b0000001, f3[i]), av[i], bv[i], lat, val, busy_cyc, va);
            el = exp_lat(f3[i], av[i], bv[i]);
            tests_run++;
            if (val !== ev[i]) begin tests_failed++; $display("FAIL dir%0d_value got %h exp %h", i, val, ev[i]); end
            tests_run++;
            if (lat !== el) begin tests_failed++; $display("FAIL dir%0d_latency got %0d exp %0d", i, lat, el); end
            tests_run++;
            if (busy_cyc !== el) begin tests_failed++; $display("FAIL dir%0d_busy_cycles got %0d exp %0d", i, busy_cyc, el); end
            tests_run++;
            if (va !== 1'b0) begin tests_failed++; $display("FAIL dir%0d_pulse_width got valid=%b next cycle exp 0", i, va); end
        end
    endtask

    task automatic test_random();
        int lat, busy_cyc, el;
        logic [31:0] val, a, b, ev;
        logic [2:0] f3;
        logic va;
        for (int i = 0; i < 40; i++) begin
            f3 = 3'(4 + $urandom_range(0, 3));
            a  = $urandom;
            case ($urandom_range(0, 4))
                0:       b = 32'h0;
                1:       b = 32'($urandom_range(1, 15));
                2:       begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                3:       b = $urandom >> $urandom_range(0, 31);
                default: b = $urandom;
            endcase
            exec_op(mk_inst(7'b0000001, f3), a, b, lat, val, busy_cyc, va);
            ev = ref_res(f3, a, b);
            el = exp_lat(f3, a, b);
            tests_run++;
            if (val !== ev) begin tests_failed++; $display("FAIL rand%0d_value f3=%0d a=%h b=%h got %h exp %h", i, f3, a, b, val, ev); end
            tests_run++;
            if (lat !== el) begin tests_failed++; $display("FAIL rand%0d_latency got %0d exp %0d", i, lat, el); end
            tests_run++;
            if (busy_cyc !== el) begin tests_failed++; $display("FAIL rand%0d_busy_cycles got %0d exp %0d", i, busy_cyc, el); end
            tests_run++;
            if (va !== 1'b0) begin tests_failed++; $display("FAIL rand%0d_pulse_width got valid=%b exp 0", i, va); end
        end
    endtask

    task automatic test_non_div();
        int busy_seen, valid_seen;
        logic [31:0] insts [2];
        insts[0] = mk_inst(7'b0000001, 3'b000);
        insts[1] = mk_inst(7'b0000000, F_DIV);
        for (int j = 0; j < 2; j++) begin
            busy_seen = 0;
            valid_seen = 0;
            bus.opcode_valid_i      = 1'b1;
            bus.opcode_opcode_i     = insts[j];
            bus.opcode_ra_operand_i = 32'd100;
            bus.opcode_rb_operand_i = 32'd7;
            @(posedge clk); #1;
            bus.opcode_valid_i = 1'b0;
            for (int k = 0; k < 40; k++) begin
                if (bus.busy_o) busy_seen++;
                if (bus.writeback_valid_o) valid_seen++;
                @(posedge clk); #1;
            end
            tests_run++;
            if (busy_seen !== 0) begin tests_failed++; $display("FAIL nondiv%0d_busy got %0d cycles exp 0", j, busy_seen); end
            tests_run++;
            if (valid_seen !== 0) begin tests_failed++; $display("FAIL nondiv%0d_valid got %0d pulses exp 0", j, valid_seen); end
        end
    endtask

    task automatic test_flush();
        int lat, busy_cyc, valid_seen;
        logic [31:0] val;
        logic va;
        exec_op(mk_inst(7'b0000001, F_DIVU), 32'd50, 32'd5, lat, val, busy_cyc, va);
        tests_run++;
        if (val !== 32'd10) begin tests_failed++; $display("FAIL flush_pre_value got %h exp %h", val, 32'd10); end
        bus.opcode_valid_i      = 1'b1;
        bus.opcode_opcode_i     = mk_inst(7'b0000001, F_DIVU);
        bus.opcode_ra_operand_i = 32'd1000;
        bus.opcode_rb_operand_i = 32'd10;
        @(posedge clk); #1;
        bus.opcode_valid_i = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        tests_run++;
        if (bus.busy_o !== 1'b1) begin tests_failed++; $display("FAIL flush_busy_before got %b exp 1", bus.busy_o); end
        bus.flush_i = 1'b1;
        @(posedge clk); #1;
        bus.flush_i = 1'b0;
        tests_run++;
        if (bus.busy_o !== 1'b0) begin tests_failed++; $display("FAIL flush_busy_after got %b exp 0", bus.busy_o); end
        valid_seen = 0;
        for (int k = 0; k < 40; k++) begin
            if (bus.writeback_valid_o) valid_seen++;
            @(posedge clk); #1;
        end
        tests_run++;
        if (valid_seen !== 0) begin tests_failed++; $display("FAIL flush_no_pulse got %0d pulses exp 0", valid_seen); end
        tests_run++;
        if (bus.writeback_value_o !== 32'd10) begin tests_failed++; $display("FAIL flush_value_held got %h exp %h", bus.writeback_value_o, 32'd10); end
        exec_op(mk_inst(7'b0000001, F_DIVU), 32'd9, 32'd3, lat, val, busy_cyc, va);
        tests_run++;
        if (val !== 32'd3) begin tests_failed++; $display("FAIL flush_next_value got %h exp 3", val); end
        tests_run++;
        if (lat !== 32) begin tests_failed++; $display("FAIL flush_next_latency got %0d exp 32", lat); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a1, b1, a2, b2, v1, v2;
        int t, seen1, seen2;
        a1 = $urandom | 32'h8000_0000;
        b1 = 32'($urandom_range(1, 1000));
        a2 = $urandom | 32'h8000_0000;
        b2 = 32'($urandom_range(1, 1000));
        v1 = '0;
        v2 = '0;
        seen1 = -1;
        seen2 = -1;
        bus.opcode_valid_i      = 1'b1;
        bus.opcode_opcode_i     = mk_inst(7'b0000001, F_DIVU);
        bus.opcode_ra_operand_i = a1;
        bus.opcode_rb_operand_i = b1;
        @(posedge clk); #1;
        bus.opcode_valid_i = 1'b0;
        t = 0;
        while (t < 100) begin
            if (bus.writeback_valid_o) begin
                seen1 = t;
                v1 = bus.writeback_value_o;
                bus.opcode_valid_i      = 1'b1;
                bus.opcode_opcode_i     = mk_inst(7'b0000001, F_REMU);
                bus.opcode_ra_operand_i = a2;
                bus.opcode_rb_operand_i = b2;
                break;
            end
            @(posedge clk); #1;
            t++;
        end
        @(posedge clk); #1;
        t++;
        bus.opcode_valid_i = 1'b0;
        tests_run++;
        if (bus.busy_o !== 1'b1) begin tests_failed++; $display("FAIL b2b_second_accept busy got %b exp 1", bus.busy_o); end
        while (t < 200) begin
            if (bus.writeback_valid_o) begin
                seen2 = t;
                v2 = bus.writeback_value_o;
                break;
            end
            @(posedge clk); #1;
            t++;
        end
        tests_run++;
        if (seen1 !== 32) begin tests_failed++; $display("FAIL b2b_first_latency got %0d exp 32", seen1); end
        tests_run++;
        if (seen2 - seen1 !== 33) begin tests_failed++; $display("FAIL b2b_pulse_spacing got %0d exp 33", seen2 - seen1); end
        tests_run++;
        if (v1 !== a1 / b1) begin tests_failed++; $display("FAIL b2b_first_value got %h exp %h", v1, a1 / b1); end
        tests_run++;
        if (v2 !== a2 % b2) begin tests_failed++; $display("FAIL b2b_second_value got %h exp %h", v2, a2 % b2); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_run();
        int valid_seen;
        bus.opcode_valid_i      = 1'b1;
        bus.opcode_opcode_i     = mk_inst(7'b0000001, F_DIVU);
        bus.opcode_ra_operand_i = 32'hFFFF_0000;
        bus.opcode_rb_operand_i = 32'd3;
        @(posedge clk); #1;
        bus.opcode_valid_i = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        tests_run++;
        if (bus.busy_o !== 1'b1) begin tests_failed++; $display("FAIL rstmid_busy_before got %b exp 1", bus.busy_o); end
        rst_i = 1'b1;
        #1;
        tests_run++;
        if (bus.busy_o !== 1'b0) begin tests_failed++; $display("FAIL rstmid_busy got %b exp 0", bus.busy_o); end
        tests_run++;
        if (bus.writeback_valid_o !== 1'b0) begin tests_failed++; $display("FAIL rstmid_valid got %b exp 0", bus.writeback_valid_o); end
        tests_run++;
        if (bus.writeback_value_o !== 32'h0) begin tests_failed++; $display("FAIL rstmid_value got %h exp 0", bus.writeback_value_o); end
        #1;
        rst_i = 1'b0;
        @(posedge clk); #1;
        valid_seen = 0;
        for (int k = 0; k < 40; k++) begin
            if (bus.writeback_valid_o || bus.busy_o) valid_seen++;
            @(posedge clk); #1;
        end
        tests_run++;
        if (valid_seen !== 0) begin tests_failed++; $display("FAIL rstmid_silent got %0d active cycles exp 0", valid_seen); end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_i                   = 1'b1;
        bus.opcode_valid_i      = 1'b0;
        bus.opcode_opcode_i     = '0;
        bus.opcode_ra_operand_i = '0;
        bus.opcode_rb_operand_i = '0;
        bus.flush_i             = 1'b0;
        test_reset();
        test_directed();
        test_random();
        test_non_div();
        test_flush();
        test_back_to_back();
        test_reset_mid_run();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
